// File: rtl/bcd_xs3_seq_conv_if.sv
// Handshake bundle for bcd_xs3_seq_conv: input word + mode, output word + error flags.
// Latency: none (wires only).
// Backpressure: in_valid_i/in_ready_o on the input side, out_valid_o/out_ready_i on the output side.
// Ports: slave = converter side, master = source/sink side. DIGITS must match the converter.
interface bcd_xs3_seq_conv_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [4*DIGITS-1:0]   in_data_i;
    logic                  mode_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [4*DIGITS-1:0]   out_data_o;
    logic                  err_o;
    logic [DIGITS-1:0]     err_mask_o;

    modport slave (
        input  in_valid_i, in_data_i, mode_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, err_o, err_mask_o
    );

    modport master (
        output in_valid_i, in_data_i, mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, err_o, err_mask_o
    );
endinterface

// File: rtl/bcd_xs3_seq_conv.sv
// Sequential BCD <-> Excess-3 converter, one digit per cycle, LSD first.
// Latency: DIGITS cycles from accept to out_valid_o; one word per DIGITS+2 cycles.
// Backpressure: holds DONE with all outputs frozen while out_ready_i is low; in_ready_o only in IDLE.
// Ports: clk_i, rst_i (sync, active-high), bus (bcd_xs3_seq_conv_if.slave):
//   in_valid_i/in_ready_o/in_data_i/mode_i (0: BCD->XS3, 1: XS3->BCD),
//   out_valid_o/out_ready_i/out_data_o/err_o/err_mask_o.
// Optional macro BCD_XS3_ERR_CHECK_EN: flags invalid digits and forces their result to 4'hF;
// without it every digit is plain modulo-16 +/-3 and err_o/err_mask_o are tied low.
module bcd_xs3_seq_conv #(
    parameter int DIGITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bcd_xs3_seq_conv_if.slave    bus
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [W-1:0]    src_q,       src_d;
    logic            mode_q,      mode_d;
    logic [W-1:0]    res_q,       res_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
`ifdef BCD_XS3_ERR_CHECK_EN
    logic [DIGITS-1:0] mask_q,    mask_d;
    logic              err_q,     err_d;
    logic              dig_bad;
`endif

    logic [3:0]      dig;
    logic [3:0]      conv;

    // Current digit and its converted value.
    always_comb begin
        dig  = src_q[{cnt_q, 2'b00} +: 4];
        conv = mode_q ? (dig - 4'd3) : (dig + 4'd3);
`ifdef BCD_XS3_ERR_CHECK_EN
        dig_bad = mode_q ? ((dig < 4'd3) || (dig > 4'd12)) : (dig > 4'd9);
        if (dig_bad) begin
            conv = 4'hF;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        mode_d      = mode_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef BCD_XS3_ERR_CHECK_EN
        mask_d      = mask_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    src_d      = bus.in_data_i;
                    mode_d     = bus.mode_i;
                    res_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CONV;
`ifdef BCD_XS3_ERR_CHECK_EN
                    mask_d     = '0;
                    err_d      = 1'b0;
`endif
                end
            end
            CONV: begin
                res_d[{cnt_q, 2'b00} +: 4] = conv;
`ifdef BCD_XS3_ERR_CHECK_EN
                mask_d[cnt_q] = dig_bad;
                err_d         = |mask_d;
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DIGITS - 1)) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Reset wins over any handshake, so an in-flight word is simply dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            src_q       <= '0;
            mode_q      <= 1'b0;
            res_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BCD_XS3_ERR_CHECK_EN
            mask_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            mode_q      <= mode_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef BCD_XS3_ERR_CHECK_EN
            mask_q      <= mask_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = res_q;
`ifdef BCD_XS3_ERR_CHECK_EN
    assign bus.err_o       = err_q;
    assign bus.err_mask_o  = mask_q;
`else
    assign bus.err_o       = 1'b0;
    assign bus.err_mask_o  = '0;
`endif
endmodule

// File: tb/tb_bcd_xs3_seq_conv.sv
// Bench for bcd_xs3_seq_conv: directed plus random words, scoreboard-checked.
// Latency: checks out_valid_o rises DIGITS edges after accept.
// Backpressure: holds out_ready_i low and confirms a pending word waits for the take.
module tb_bcd_xs3_seq_conv;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst;

    bcd_xs3_seq_conv_if #(.DIGITS(DIGITS)) bus ();

    bcd_xs3_seq_conv #(.DIGITS(DIGITS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]      data;
        logic [DIGITS-1:0] mask;
        int                acc;
    } exp_t;

    exp_t q[$];

    bit   rdy_mode  = 1'b0;
    logic rdy_force = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: each digit treated as an integer 0..15, shifted by +/-3 modulo 16.
    function automatic exp_t model(input logic [W-1:0] d, input logic m);
        exp_t e;
        int   v;
        int   r;
        e.data = '0;
        e.mask = '0;
        e.acc  = 0;
        for (int k = 0; k < DIGITS; k++) begin
            v = int'(d[4*k +: 4]);
            r = m ? (v + 16 - 3) % 16 : (v + 3) % 16;
`ifdef BCD_XS3_ERR_CHECK_EN
            begin
                bit ok;
                ok = m ? (v >= 3 && v <= 12) : (v <= 9);
                if (!ok) begin
                    r = 15;
                    e.mask[k] = 1'b1;
                end
            end
`endif
            e.data[4*k +: 4] = 4'(r);
        end
        return e;
    endfunction

    // Sink ready driver; runs at posedge+2 so the main thread's posedge+1 writes are seen.
    initial begin
        forever begin
            bus.out_ready_i = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
            @(posedge clk);
            #2;
        end
    end

    // Monitor: compares every taken result against the scoreboard.
    initial begin
        exp_t e;
        bit   chk_rdy;
        logic prev_vld;
        chk_rdy  = 1'b0;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                chk_rdy = 1'b0;
            end else begin
                if (chk_rdy) begin
                    check("in_ready_after_take", 64'(bus.in_ready_o), 64'd1);
                    chk_rdy = 1'b0;
                end
                if (bus.in_ready_o && bus.out_valid_o) begin
                    flag("ready_valid_both_high");
                end
                if (bus.out_valid_o && !prev_vld) begin
                    if (q.size() == 0) flag("unexpected_out_valid");
                    else check("latency", 64'(cyc - q[0].acc), 64'(DIGITS));
                end
                if (bus.out_valid_o && bus.out_ready_i) begin
                    if (q.size() == 0) begin
                        flag("take_without_expected");
                    end else begin
                        e = q.pop_front();
                        check("out_data", 64'(bus.out_data_o), 64'(e.data));
                        check("err_mask", 64'(bus.err_mask_o), 64'(e.mask));
                        check("err", 64'(bus.err_o), 64'(|e.mask));
                        chk_rdy = 1'b1;
                    end
                end
            end
            prev_vld = bus.out_valid_o;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic m);
        exp_t e;
        int   t;
        t = 0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        bus.mode_i     = m;
        @(negedge clk);
        while (!bus.in_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready_o) begin
            flag("accept_timeout");
            bus.in_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e     = model(d, m);
        e.acc = cyc;
        q.push_back(e);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((q.size() != 0 || !bus.in_ready_o) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || !bus.in_ready_o) flag("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst            = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        bus.mode_i     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_out_data",  64'(bus.out_data_o),  64'd0);
        check("rst_err",       64'(bus.err_o),       64'd0);
        check("rst_err_mask",  64'(bus.err_mask_o),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed words with the sink always ready.
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        send(16'h1234, 1'b0);
        drain();
        send(16'h4567, 1'b1);
        drain();
        send(16'h9A05, 1'b0);
        drain();
        send(16'h0C3F, 1'b1);
        drain();

        // Backpressure: result held for 5 cycles while a second word is waiting.
        rdy_force = 1'b0;
        @(posedge clk);
        #3;
        send(16'h2468, 1'b0);
        t = 0;
        @(negedge clk);
        while (!bus.out_valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid_o) flag("bp_valid_timeout");
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 16'h1111;
        bus.mode_i     = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid_o), 64'd1);
            if (q.size() == 0) begin
                flag("bp_queue_empty");
            end else begin
                check("bp_out_data", 64'(bus.out_data_o), 64'(q[0].data));
                check("bp_err_mask", 64'(bus.err_mask_o), 64'(q[0].mask));
            end
        end
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        send(16'h1111, 1'b0);
        drain();

        // Reset after two digits have been converted.
        send(16'h5555, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_out_data",  64'(bus.out_data_o),  64'd0);
        check("midrst_err_mask",  64'(bus.err_mask_o),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(16'h0987, 1'b0);
        drain();

        // Random words, random sink readiness, random gaps.
        rdy_mode = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            send(d, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        rdy_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
